// File: rtl/bpsk_pkg.sv
// Shared defaults and state encoding for the coherent BPSK demodulator.
// Imported by the MAC and the demodulator top.
package bpsk_pkg;

  localparam int SPS_DEF   = 1280;
  localparam int ACC_W_DEF = 48;
  localparam int CNT_W     = 16;
  localparam int LK_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    DUMP  = 2'd2
  } state_t;

endpackage

// File: rtl/bpsk_mac.sv
// Signed 16x16 multiply-accumulate with load, clear and hold.
// sum is the running total including the current product.
module bpsk_mac
  import bpsk_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clr,
  input  logic                    add,
  input  logic signed [15:0]      a,
  input  logic signed [15:0]      b,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc;

  assign prod   = a * b;
  assign prod_x = {{(ACC_W-32){prod[31]}}, prod};
  assign sum    = acc + prod_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= prod_x;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/bpsk_demod.sv
// Integrate-and-dump BPSK demodulator with symbol resync,
// weak-symbol flag and consecutive-strong-symbol lock detect.
module bpsk_demod
  import bpsk_pkg::*;
#(
  parameter int               SPS    = SPS_DEF,
  parameter int               ACC_W  = ACC_W_DEF,
  parameter logic [ACC_W-1:0] THRESH = ACC_W'(1024),
  parameter int               LOCK_N = 4
) (
  input  logic        clk_sig,
  input  logic        rst_sig,
  input  logic        en_p,
  input  logic [15:0] bpsk_sig,
  input  logic [15:0] carrier_sig,
  input  logic        sym_sync,
  output logic        demod_sig,
  output logic        bit_valid,
  output logic        weak_sig,
  output logic        lock_sig
);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [LK_W-1:0]         lk;
  logic [LK_W-1:0]         lk_nx;
  logic signed [ACC_W-1:0] s;
  logic [ACC_W-1:0]        mag;
  logic                    sync;
  logic                    dump;
  logic                    weak_nx;

  assign sync = en_p & sym_sync;
  assign dump = en_p & ~sym_sync & (cnt == CNT_W'(SPS - 1));

  bpsk_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk_sig),
    .rst  (rst_sig),
    .load (sync),
    .clr  (dump),
    .add  (en_p),
    .a    (bpsk_sig),
    .b    (carrier_sig),
    .sum  (s)
  );

  // s = 0 has zero magnitude, so it always lands on the weak side
  assign mag     = s[ACC_W-1] ? $unsigned(-s) : $unsigned(s);
  assign weak_nx = mag < THRESH;

  always_comb begin
    lk_nx = '0;
    if (!weak_nx) begin
      lk_nx = (lk == LK_W'(LOCK_N)) ? lk : lk + LK_W'(1);
    end
  end

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      state     <= IDLE;
      cnt       <= '0;
      lk        <= '0;
      demod_sig <= 1'b0;
      bit_valid <= 1'b0;
      weak_sig  <= 1'b1;
      lock_sig  <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (sync) begin
        cnt      <= CNT_W'(1);
        lk       <= '0;
        lock_sig <= 1'b0;
        state    <= INTEG;
      end else if (dump) begin
        cnt       <= '0;
        demod_sig <= ~s[ACC_W-1] & (|s);
        weak_sig  <= weak_nx;
        bit_valid <= 1'b1;
        lk        <= lk_nx;
        lock_sig  <= (lk_nx == LK_W'(LOCK_N));
        state     <= DUMP;
      end else if (en_p) begin
        cnt   <= cnt + CNT_W'(1);
        state <= INTEG;
      end else if (state == DUMP) begin
        state <= INTEG;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod: symbol-level reference model
// compared every cycle, plus directed literal expectations.
module tb_bpsk_demod;

  localparam int SPS    = 1280;
  localparam int THRESH = 1024;
  localparam int LOCK_N = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b0;
  logic               sy  = 1'b0;
  logic signed [15:0] b   = '0;
  logic signed [15:0] c   = '0;
  logic               demod_sig;
  logic               bit_valid;
  logic               weak_sig;
  logic               lock_sig;

  bpsk_demod dut (
    .clk_sig     (clk),
    .rst_sig     (rst),
    .en_p        (en),
    .bpsk_sig    (b),
    .carrier_sig (c),
    .sym_sync    (sy),
    .demod_sig   (demod_sig),
    .bit_valid   (bit_valid),
    .weak_sig    (weak_sig),
    .lock_sig    (lock_sig)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint m_sum   = 0;
  int     m_n     = 0;
  int     m_lk    = 0;
  bit     m_valid = 1'b0;
  bit     m_demod = 1'b0;
  bit     m_weak  = 1'b1;
  bit     m_lock  = 1'b0;

  int cyc        = 0;
  int dut_pulses = 0;
  int pulse_cyc  = -1;
  int last_acc   = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sum   = 0;
    m_n     = 0;
    m_lk    = 0;
    m_valid = 1'b0;
    m_demod = 1'b0;
    m_weak  = 1'b1;
    m_lock  = 1'b0;
  endtask

  // Symbol-level reference: m_n samples gathered so far in this symbol
  task automatic model_edge();
    longint p;
    longint mag;
    if (rst) begin
      model_reset();
      return;
    end
    m_valid = 1'b0;
    if (!en) return;
    p = longint'(b) * longint'(c);
    if (sy) begin
      m_sum  = p;
      m_n    = 1;
      m_lk   = 0;
      m_lock = 1'b0;
    end else begin
      m_sum += p;
      m_n++;
      if (m_n == SPS) begin
        mag     = (m_sum < 0) ? -m_sum : m_sum;
        m_valid = 1'b1;
        m_demod = (m_sum > 0);
        m_weak  = (mag < THRESH);
        if (m_weak) m_lk = 0;
        else if (m_lk < LOCK_N) m_lk++;
        m_lock = (m_lk == LOCK_N);
        m_sum  = 0;
        m_n    = 0;
      end
    end
  endtask

  task automatic step(input bit e, input logic signed [15:0] bb,
                      input logic signed [15:0] cc, input bit s);
    @(negedge clk);
    #1;
    en = e;
    b  = bb;
    c  = cc;
    sy = s;
    @(posedge clk);
    cyc++;
    model_edge();
    if (e && !rst) last_acc = cyc;
  endtask

  task automatic sym(input int n, input logic signed [15:0] bb,
                     input bit sync_first, input bit gaps);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bb, 16'sd1000, sync_first && (i == 0));
      if (gaps) step(1'b0, bb, 16'sd1000, 1'b1);
    end
    step(1'b0, 16'sd0, 16'sd0, 1'b0);
    #1;
  endtask

  always @(negedge clk) begin
    check("bit_valid", bit_valid, m_valid);
    check("demod_sig", demod_sig, m_demod);
    check("weak_sig", weak_sig, m_weak);
    check("lock_sig", lock_sig, m_lock);
    if (bit_valid) begin
      dut_pulses++;
      pulse_cyc = cyc;
    end
  end

  function automatic logic signed [15:0] carr(input int i);
    case (i % 8)
      0, 4:    return 16'sd0;
      1, 3:    return 16'sd7071;
      2:       return 16'sd10000;
      5, 7:    return -16'sd7071;
      default: return -16'sd10000;
    endcase
  endfunction

  initial begin
    int p0;
    int acc_mark;
    int locked;
    logic [3:0] lfsr;
    logic       bitv;
    logic signed [15:0] cv;

    #1 rst = 1'b1;
    #2;
    check("rst_valid", bit_valid, 0);
    check("rst_demod", demod_sig, 0);
    check("rst_weak", weak_sig, 1);
    check("rst_lock", lock_sig, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    p0 = dut_pulses;
    sym(SPS, 16'sd1000, 1'b0, 1'b0);
    check("c1_pulses", dut_pulses - p0, 1);
    check("c1_latency", pulse_cyc, last_acc);
    check("c1_demod", demod_sig, 1);
    check("c1_weak", weak_sig, 0);

    for (int k = 0; k < 4; k++) begin
      sym(SPS, -16'sd1000, k == 0, 1'b0);
      check("flip_demod", demod_sig, 0);
      check("flip_weak", weak_sig, 0);
      check("flip_lock", lock_sig, k == 3);
    end

    sym(SPS, 16'sd0, 1'b0, 1'b0);
    check("weak_demod", demod_sig, 0);
    check("weak_weak", weak_sig, 1);
    check("weak_lock", lock_sig, 0);

    p0 = dut_pulses;
    for (int i = 0; i < 500; i++) step(1'b1, 16'sd1000, 16'sd1000, 1'b0);
    sym(SPS, 16'sd1000, 1'b1, 1'b0);
    check("sync_pulses", dut_pulses - p0, 1);
    check("sync_latency", pulse_cyc, last_acc);
    check("sync_demod", demod_sig, 1);
    check("sync_lock", lock_sig, 0);

    p0 = dut_pulses;
    acc_mark = cyc;
    sym(SPS, 16'sd1000, 1'b0, 1'b1);
    check("gap_pulses", dut_pulses - p0, 1);
    check("gap_latency", pulse_cyc, last_acc);
    check("gap_span", pulse_cyc - acc_mark, 2 * SPS - 1);
    check("gap_demod", demod_sig, 1);
    check("gap_weak", weak_sig, 0);

    for (int i = 0; i < 700; i++) step(1'b1, -16'sd1000, 16'sd1000, 1'b0);
    @(negedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", bit_valid, 0);
    check("arst_demod", demod_sig, 0);
    check("arst_weak", weak_sig, 1);
    check("arst_lock", lock_sig, 0);
    step(1'b0, 16'sd0, 16'sd0, 1'b0);
    step(1'b0, 16'sd0, 16'sd0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    p0 = dut_pulses;
    sym(SPS, -16'sd1000, 1'b0, 1'b0);
    check("arst_pulses", dut_pulses - p0, 1);
    check("arst_latency", pulse_cyc, last_acc);
    check("arst_dec", demod_sig, 0);

    lfsr   = 4'b0001;
    locked = 0;
    for (int k = 0; k < 16; k++) begin
      bitv = lfsr[3];
      for (int i = 0; i < SPS; i++) begin
        cv = carr(i);
        step(1'b1, bitv ? cv : -cv, cv, (k == 0) && (i == 0));
      end
      #1;
      check("mseq_valid", bit_valid, 1);
      if (lock_sig) begin
        check("mseq_bit", demod_sig, bitv);
        locked++;
      end
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
    step(1'b0, 16'sd0, 16'sd0, 1'b0);
    check("mseq_locked", locked, 13);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
